// File: rtl/eq_scoreboard.sv
// eq_scoreboard: expected-word FIFO checker comparing actual words, with statistics and first-error capture
module eq_scoreboard #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [W-1:0]             exp_data,
    input  logic                     act_valid,
    input  logic [W-1:0]             act_data,
    output logic                     res_valid,
    output logic [1:0]               res_code,
    output logic [CW-1:0]            match_cnt,
    output logic [CW-1:0]            mismatch_cnt,
    output logic [CW-1:0]            unknown_cnt,
    output logic [CW-1:0]            underflow_cnt,
    output logic                     err_sticky,
    output logic [W-1:0]             first_err_exp,
    output logic [W-1:0]             first_err_act,
    output logic                     first_err_vld,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [W-1:0]  head;
    logic [1:0]    code;
    logic          push, pop, under, err;

    assign exp_ready = level != LW'(DEPTH);
    assign push      = exp_valid && exp_ready;
    assign pop       = act_valid && level != '0;
    assign under     = act_valid && level == '0;
    assign head      = mem[rp];
    assign err       = act_valid && code != 2'b00;

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] c, input logic en);
        return (en && c != '1) ? c + CW'(1) : c;
    endfunction

    // classify the current beat; an X/Z anywhere makes the reduction XOR unknown
    always_comb begin
        code = under ? 2'b11 :
               mode  ? ((head === act_data) ? 2'b00 : 2'b01) :
               ((^{head, act_data}) === 1'bx) ? 2'b10 :
               (head == act_data) ? 2'b00 : 2'b01;
    end

    // FIFO storage needs no reset; occupancy is tracked by level
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wp] <= exp_data;
    end

    // pointers, registered result, saturating statistics and first-error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp            <= '0;
            rp            <= '0;
            level         <= '0;
            res_valid     <= 1'b0;
            res_code      <= 2'b00;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            unknown_cnt   <= '0;
            underflow_cnt <= '0;
            err_sticky    <= 1'b0;
            first_err_exp <= '0;
            first_err_act <= '0;
            first_err_vld <= 1'b0;
        end else if (clear) begin
            wp            <= '0;
            rp            <= '0;
            level         <= '0;
            res_valid     <= 1'b0;
            res_code      <= 2'b00;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            unknown_cnt   <= '0;
            underflow_cnt <= '0;
            err_sticky    <= 1'b0;
            first_err_exp <= '0;
            first_err_act <= '0;
            first_err_vld <= 1'b0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            level         <= level + LW'(push) - LW'(pop);
            res_valid     <= act_valid;
            if (act_valid) res_code <= code;
            match_cnt     <= bump(match_cnt,     act_valid && code == 2'b00);
            mismatch_cnt  <= bump(mismatch_cnt,  act_valid && code == 2'b01);
            unknown_cnt   <= bump(unknown_cnt,   act_valid && code == 2'b10);
            underflow_cnt <= bump(underflow_cnt, act_valid && code == 2'b11);
            if (err) err_sticky <= 1'b1;
            if (err && !first_err_vld) begin
                first_err_exp <= under ? '0 : head;
                first_err_act <= act_data;
                first_err_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_eq_scoreboard.sv
// tb_eq_scoreboard: directed bench for eq_scoreboard with a CW=2 twin for saturation
module tb_eq_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n, clear, mode, exp_valid, act_valid;
    logic [3:0] exp_data, act_data;

    logic       exp_ready, res_valid, err_sticky, first_err_vld;
    logic [1:0] res_code;
    logic [7:0] match_cnt, mismatch_cnt, unknown_cnt, underflow_cnt;
    logic [3:0] first_err_exp, first_err_act;
    logic [2:0] level;

    logic       s_exp_ready, s_res_valid, s_err_sticky, s_first_err_vld;
    logic [1:0] s_res_code;
    logic [1:0] s_match_cnt, s_mismatch_cnt, s_unknown_cnt, s_underflow_cnt;
    logic [3:0] s_first_err_exp, s_first_err_act;
    logic [2:0] s_level;

    int n_chk = 0;
    int n_pass = 0;
    int m_match, m_mis, m_unk;
    logic       m_fv;
    logic [3:0] m_fe, m_fa;

    always #5 clk = ~clk;

    eq_scoreboard #(.W(4), .DEPTH(4), .CW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .act_valid(act_valid), .act_data(act_data),
        .res_valid(res_valid), .res_code(res_code),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
        .unknown_cnt(unknown_cnt), .underflow_cnt(underflow_cnt),
        .err_sticky(err_sticky), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act), .first_err_vld(first_err_vld),
        .level(level)
    );

    eq_scoreboard #(.W(4), .DEPTH(4), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .exp_valid(exp_valid), .exp_ready(s_exp_ready), .exp_data(exp_data),
        .act_valid(act_valid), .act_data(act_data),
        .res_valid(s_res_valid), .res_code(s_res_code),
        .match_cnt(s_match_cnt), .mismatch_cnt(s_mismatch_cnt),
        .unknown_cnt(s_unknown_cnt), .underflow_cnt(s_underflow_cnt),
        .err_sticky(s_err_sticky), .first_err_exp(s_first_err_exp),
        .first_err_act(s_first_err_act), .first_err_vld(s_first_err_vld),
        .level(s_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) $display("FAIL %s: got %h expected %h", tag, got, want);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_code(input logic m, input logic [3:0] e, input logic [3:0] a);
        if (m) return (e === a) ? 2'b00 : 2'b01;
        return $isunknown({e, a}) ? 2'b10 : (e == a) ? 2'b00 : 2'b01;
    endfunction

    task automatic push(input logic [3:0] d);
        exp_valid = 1'b1;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic act(input logic [3:0] d, input logic m);
        act_valid = 1'b1;
        act_data  = d;
        mode      = m;
        tick();
        act_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [3:0] e, input logic [3:0] a, input logic m);
        logic [1:0] c;
        c = ref_code(m, e, a);
        push(e);
        act(a, m);
        chk({tag, "_vld"}, res_valid, 1);
        chk({tag, "_code"}, res_code, c);
        if (c == 2'b00) m_match++;
        if (c == 2'b01) m_mis++;
        if (c == 2'b10) m_unk++;
        if (c != 2'b00 && !m_fv) begin
            m_fv = 1'b1;
            m_fe = e;
            m_fa = a;
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; mode = 1'b0;
        exp_valid = 1'b0; act_valid = 1'b0; exp_data = '0; act_data = '0;
        tick();
        tick();
        chk("rst_ready", exp_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_code", res_code, 0);
        chk("rst_match", match_cnt, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_fvld", first_err_vld, 0);
        chk("rst_fexp", first_err_exp, 0);
        rst_n = 1'b1;
        tick();

        push(4'b0000);
        push(4'b0010);
        chk("t1_level2", level, 2);
        act(4'b0000, 1'b0);
        chk("t1_a_vld", res_valid, 1);
        chk("t1_a_code", res_code, 2'b00);
        act(4'b0010, 1'b0);
        chk("t1_b_vld", res_valid, 1);
        chk("t1_b_code", res_code, 2'b00);
        tick();
        chk("t1_idle_vld", res_valid, 0);
        chk("t1_match", match_cnt, 2);
        chk("t1_sticky", err_sticky, 0);
        chk("t1_level0", level, 0);

        m_match = 2; m_mis = 0; m_unk = 0; m_fv = 1'b0; m_fe = '0; m_fa = '0;
        beat("x_logic", 4'b0000, 4'b00x0, 1'b0);
        chk("x_fexp_first", first_err_exp, m_fe);
        chk("x_fact_first", first_err_act, m_fa);
        beat("x_case_eq", 4'b00x0, 4'b00x0, 1'b1);
        beat("x_case_ne", 4'b0000, 4'b00x0, 1'b1);
        chk("x_match", match_cnt, m_match);
        chk("x_mis", mismatch_cnt, m_mis);
        chk("x_unk", unknown_cnt, m_unk);
        chk("x_fvld", first_err_vld, m_fv);
        chk("x_fexp", first_err_exp, m_fe);
        chk("x_fact", first_err_act, m_fa);
        chk("x_sticky", err_sticky, m_fv);

        do_clear();
        chk("clr_match", match_cnt, 0);
        chk("clr_level", level, 0);
        chk("clr_vld", res_valid, 0);

        for (int i = 1; i <= 4; i++) push(4'(i));
        chk("full_ready", exp_ready, 0);
        chk("full_level", level, 4);
        push(4'hf);
        chk("full_ign_level", level, 4);
        exp_valid = 1'b1; exp_data = 4'he;
        act(4'd1, 1'b0);
        exp_valid = 1'b0;
        chk("full_pop_level", level, 3);
        chk("full_pop_ready", exp_ready, 1);
        chk("full_pop_code", res_code, 2'b00);
        for (int i = 0; i < 4; i++) begin
            exp_valid = 1'b1; exp_data = 4'(5 + i);
            act(4'(2 + i), 1'b0);
            exp_valid = 1'b0;
            chk("stream_code", res_code, 2'b00);
            chk("stream_level", level, 3);
        end
        for (int i = 6; i <= 8; i++) begin
            act(4'(i), 1'b0);
            chk("drain_code", res_code, 2'b00);
        end
        chk("order_match", match_cnt, 8);
        chk("order_mis", mismatch_cnt, 0);
        chk("order_level", level, 0);

        exp_valid = 1'b1; exp_data = 4'b0101;
        act(4'b1111, 1'b0);
        exp_valid = 1'b0;
        chk("und_code", res_code, 2'b11);
        chk("und_cnt", underflow_cnt, 1);
        chk("und_level", level, 1);
        chk("und_sticky", err_sticky, 1);
        chk("und_fvld", first_err_vld, 1);
        chk("und_fexp", first_err_exp, 4'b0000);
        chk("und_fact", first_err_act, 4'b1111);
        act(4'b0101, 1'b0);
        chk("und_next_code", res_code, 2'b00);

        do_clear();
        for (int i = 0; i < 5; i++) begin
            push(4'b0001);
            act(4'b0010, 1'b0);
            chk("sat_code", res_code, 2'b01);
        end
        chk("sat_wide_mis", mismatch_cnt, 5);
        chk("sat_narrow_mis", s_mismatch_cnt, 3);
        clear = 1'b1; act_valid = 1'b1; act_data = 4'b0001;
        tick();
        clear = 1'b0; act_valid = 1'b0;
        chk("clract_vld", res_valid, 0);
        chk("clract_mis", mismatch_cnt, 0);
        chk("clract_sat_mis", s_mismatch_cnt, 0);
        chk("clract_und", underflow_cnt, 0);
        chk("clract_sticky", err_sticky, 0);
        chk("clract_fvld", first_err_vld, 0);
        chk("clract_ready", exp_ready, 1);
        tick();
        chk("clract_next_vld", res_valid, 0);

        for (int i = 1; i <= 4; i++) push(4'(i));
        act(4'd1, 1'b0);
        chk("arst_pre_level", level, 3);
        chk("arst_pre_vld", res_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_ready", exp_ready, 1);
        chk("arst_vld", res_valid, 0);
        chk("arst_match", match_cnt, 0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_after_vld", res_valid, 0);
        chk("arst_after_level", level, 0);
        push(4'b1010);
        act(4'b1010, 1'b0);
        chk("arst_resume_code", res_code, 2'b00);
        chk("arst_resume_match", match_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
